imem_loader: RTL and testbench

- Boot-time writer for the instruction memory. It sits on the opposite end of the fetch interface.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian N-bit instruction words.
- Issues one write per word into the instruction RAM at addresses 0, 1, 2, … in order.
- Holds the pipeline in reset until loading completes, then releases it to fetch from address 0.

---
 rtl/imem_loader.sv | 197 +++++++++++++++++++
 tb/tb_imem_loader.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory.
// Takes a byte stream over a valid/ready handshake and assembles little-endian
// N-bit words. Each word is written to the instruction RAM at addresses 0, 1, 2, ...
// The processor pipeline is held in reset until the whole load has been written.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to enable a trailing checksum word.
// The loader keeps a running XOR of all written words. After the last write it accepts
// one extra word and compares it with that XOR; a mismatch sets csum_err. With the macro
// undefined, csum_err is tied to 0.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start, word_count   load request pulse and word count (clamped to 2**ADDR_W)
//   byte_in, byte_valid stream byte and its valid flag
//   byte_ready          the loader accepts a byte on this cycle
//   we, waddr, wdata    instruction-memory write port
//   busy, done          load in progress / load complete
//   cpu_hold            holds the pipeline in reset (deasserted only when done)
//   csum_err            checksum mismatch flag
module imem_loader #(
    parameter int unsigned N      = 32,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [N-1:0]      wdata,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold,
    output logic              csum_err
);

    localparam int unsigned NB = N / 8;
    localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned CW = ADDR_W + 1;
    localparam logic [CW-1:0] Depth = {1'b1, {ADDR_W{1'b0}}};

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {StIdle, StRecv, StWrite, StDone, StCsum} state_e;
`else
    typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_e;
`endif

    state_e            state_q, state_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic [N-1:0]      asm_q, asm_d;
    logic [CW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     count_q, count_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [N-1:0]      wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [N-1:0]      csum_q, csum_d;
    logic              err_q, err_d;
`endif

    logic          accept;
    logic          last_byte;
    logic [N-1:0]  word_full;
    logic [CW-1:0] new_count;
    state_e        after_last;

    always_comb begin
        byte_ready = (state_q == StRecv);
`ifdef IMEM_LOADER_CHECKSUM_EN
        byte_ready = byte_ready || (state_q == StCsum);
`endif
        we       = (state_q == StWrite);
        busy     = byte_ready || we;
        done     = (state_q == StDone);
        cpu_hold = !done;
        waddr    = waddr_q;
        wdata    = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_err = err_q;
`else
        csum_err = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        idx_d   = idx_q;
        count_d = count_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
        err_d      = err_q;
        after_last = StCsum;
`else
        after_last = StDone;
`endif
        accept    = byte_ready && byte_valid;
        last_byte = (bcnt_q == BW'(NB - 1));
        // Current partial word with the incoming byte merged into its lane.
        word_full = asm_q;
        word_full[int'(bcnt_q) * 8 +: 8] = byte_in;
        new_count = (word_count > Depth) ? Depth : word_count;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    count_d = new_count;
                    idx_d   = '0;
                    bcnt_d  = '0;
                    asm_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = '0;
                    err_d  = 1'b0;
`endif
                    // An empty load still goes through the checksum word when enabled.
                    state_d = (new_count == '0) ? after_last : StRecv;
                end
            end
            StRecv: begin
                if (accept) begin
                    if (last_byte) begin
                        wdata_d = word_full;
                        waddr_d = idx_q[ADDR_W-1:0];
                        bcnt_d  = '0;
                        asm_d   = '0;
                        state_d = StWrite;
                    end else begin
                        asm_d  = word_full;
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            StWrite: begin
                asm_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_d = csum_q ^ wdata_q;
`endif
                if (idx_q == count_q - 1'b1) begin
                    state_d = after_last;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StRecv;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            StCsum: begin
                if (accept) begin
                    if (last_byte) begin
                        err_d   = (word_full != csum_q);
                        bcnt_d  = '0;
                        asm_d   = '0;
                        state_d = StDone;
                    end else begin
                        asm_d  = word_full;
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            bcnt_q  <= '0;
            asm_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q <= '0;
            err_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q <= csum_d;
            err_q  <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (N=32, ADDR_W=6).
module tb_imem_loader;
    localparam int N      = 32;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W:0]   word_count = '0;
    logic [7:0]        byte_in = '0;
    logic              byte_valid = 1'b0;
    logic              byte_ready, we, busy, done, cpu_hold, csum_err;
    logic [ADDR_W-1:0] waddr;
    logic [N-1:0]      wdata;

    imem_loader #(.N(N), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .word_count(word_count),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done),
        .cpu_hold(cpu_hold), .csum_err(csum_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus byte stream, expected written words, and observed writes.
    logic [7:0]        stim_q[$];
    logic [31:0]       stim_x;
    logic [31:0]       exp_q[$];
    logic [ADDR_W-1:0] wa_q[$];
    logic [N-1:0]      wd_q[$];
    logic              prev_we = 1'b0;

    always @(negedge clk) begin
        if (we === 1'b1) begin
            wa_q.push_back(waddr);
            wd_q.push_back(wdata);
            n_tests++;
            if (byte_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL we_ready: byte_ready=%b during write, want 0", byte_ready);
            end
            n_tests++;
            if (prev_we === 1'b1) begin
                n_fail++;
                $display("FAIL we_double: we=1 on two consecutive cycles, want single pulse");
            end
        end
        prev_we = we;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit hit, want completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_stim();
        stim_q.delete();
        exp_q.delete();
        wa_q.delete();
        wd_q.delete();
        stim_x = '0;
    endtask

    // Word goes out LSB first; a written word also joins the expected list and XOR.
    task automatic push_word(input logic [31:0] w, input bit written);
        for (int k = 0; k < 4; k++) stim_q.push_back(8'((w >> (8 * k)) & 32'hff));
        if (written) begin
            exp_q.push_back(w);
            stim_x = stim_x ^ w;
        end
    endtask

    task automatic close_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
        push_word(stim_x, 1'b0);
`endif
    endtask

    task automatic pulse_start(input int cnt);
        @(negedge clk);
        start = 1'b1;
        word_count = cnt[ADDR_W:0];
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // mode 0: valid held high, 1: toggled every cycle, 2: random
    task automatic feed(input int mode);
        int i = 0;
        int guard = 0;
        bit acc;
        bit tog = 1'b1;
        while (i < stim_q.size() && guard < 5000) begin
            @(negedge clk);
            guard++;
            byte_in = stim_q[i];
            case (mode)
                0: byte_valid = 1'b1;
                1: begin byte_valid = tog; tog = ~tog; end
                default: byte_valid = ($urandom_range(0, 3) != 0);
            endcase
            acc = byte_valid && (byte_ready === 1'b1);
            @(posedge clk);
            #1;
            if (acc) i++;
        end
        byte_valid = 1'b0;
        n_tests++;
        if (i != stim_q.size()) begin
            n_fail++;
            $display("FAIL feed_timeout: accepted %0d bytes, want %0d", i, stim_q.size());
        end
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (done !== 1'b1 && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_timeout: done=%b after %0d cycles, want 1", done, c);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests += 8;
        if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: %b want 0", byte_ready); end
        if (we !== 1'b0)         begin n_fail++; $display("FAIL rst_we: %b want 0", we); end
        if (waddr !== '0)        begin n_fail++; $display("FAIL rst_waddr: %0d want 0", waddr); end
        if (wdata !== '0)        begin n_fail++; $display("FAIL rst_wdata: %h want 0", wdata); end
        if (busy !== 1'b0)       begin n_fail++; $display("FAIL rst_busy: %b want 0", busy); end
        if (done !== 1'b0)       begin n_fail++; $display("FAIL rst_done: %b want 0", done); end
        if (cpu_hold !== 1'b1)   begin n_fail++; $display("FAIL rst_hold: %b want 1", cpu_hold); end
        if (csum_err !== 1'b0)   begin n_fail++; $display("FAIL rst_csum: %b want 0", csum_err); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        clear_stim();
        push_word(32'hf8000001, 1'b1);
        push_word(32'hf8008002, 1'b1);
        close_load();
        pulse_start(2);
        fork
            feed(0);
            begin
                repeat (9) @(posedge clk);
                #1;
`ifndef IMEM_LOADER_CHECKSUM_EN
                n_tests++;
                if (done !== 1'b0) begin n_fail++; $display("FAIL basic_early: done=%b at cycle 9, want 0", done); end
                @(posedge clk);
                #1;
                n_tests++;
                if (done !== 1'b1 || cpu_hold !== 1'b0) begin
                    n_fail++;
                    $display("FAIL basic_c10: done=%b hold=%b at cycle 10, want 1/0", done, cpu_hold);
                end
`endif
            end
        join
        wait_done(50);
        n_tests++;
        if (wd_q.size() != 2) begin n_fail++; $display("FAIL basic_count: %0d writes, want 2", wd_q.size()); end
        foreach (exp_q[i]) if (i < wd_q.size()) begin
            n_tests++;
            if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL basic_w%0d: %0d/%h want %0d/%h", i, wa_q[i], wd_q[i], i, exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_stim();
        push_word(32'hb400001f, 1'b1);
        close_load();
        pulse_start(1);
        feed(1);
        wait_done(50);
        n_tests++;
        if (wd_q.size() != 1 || wa_q[0] !== '0 || wd_q[0] !== 32'hb400001f) begin
            n_fail++;
            $display("FAIL bp_write: %0d writes first=%h, want 1 write of b400001f at 0",
                     wd_q.size(), (wd_q.size() > 0) ? wd_q[0] : 32'h0);
        end
    endtask

    task automatic test_full();
        int reqs[2] = '{64, 100};
        foreach (reqs[r]) begin
            clear_stim();
            for (int i = 0; i < 64; i++) push_word(32'(i), 1'b1);
            close_load();
            pulse_start(reqs[r]);
            feed(2);
            wait_done(100);
            repeat (5) @(posedge clk);
            #1;
            n_tests++;
            if (wd_q.size() != 64) begin n_fail++; $display("FAIL full_count%0d: %0d writes, want 64", reqs[r], wd_q.size()); end
            foreach (exp_q[i]) if (i < wd_q.size()) begin
                n_tests++;
                if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL full%0d_w%0d: %0d/%h want %0d/%h", reqs[r], i, wa_q[i], wd_q[i], i, exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_stim();
        for (int i = 0; i < 3; i++) push_word($urandom, 1'b1);
        while (stim_q.size() > 6) void'(stim_q.pop_back());
        pulse_start(3);
        feed(0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        n_tests++;
        if (done !== 1'b0 || cpu_hold !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_state: done=%b hold=%b busy=%b ready=%b want 0/1/0/0",
                     done, cpu_hold, busy, byte_ready);
        end
        byte_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1 byte_valid = 1'b0;
        n_tests++;
        if (wd_q.size() != 1 || wa_q[0] !== '0 || wd_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL rmid_writes: %0d writes, want 1 at addr 0 of %h", wd_q.size(), exp_q[0]);
        end
    endtask

    task automatic test_corner();
        int c = 0;
        clear_stim();
        close_load();
        pulse_start(0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        feed(0);
        wait_done(10);
`else
        while (done !== 1'b1 && c < 1) begin @(posedge clk); #1; c++; end
        n_tests++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: done=%b, want 1 within 2 cycles", done); end
`endif
        n_tests++;
        if (wd_q.size() != 0 || cpu_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_writes: %0d writes hold=%b, want 0/0", wd_q.size(), cpu_hold);
        end
        clear_stim();
        push_word($urandom, 1'b1);
        push_word($urandom, 1'b1);
        close_load();
        pulse_start(2);
        fork
            feed(2);
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                start = 1'b1;
                word_count = 7'd7;
                @(posedge clk);
                #1 start = 1'b0;
            end
        join
        wait_done(50);
        repeat (10) @(posedge clk);
        #1;
        n_tests++;
        if (wd_q.size() != 2 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_start: %0d writes done=%b, want 2/1", wd_q.size(), done);
        end
        foreach (exp_q[i]) if (i < wd_q.size()) begin
            n_tests++;
            if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL busy_w%0d: %0d/%h want %0d/%h", i, wa_q[i], wd_q[i], i, exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int cnt = $urandom_range(1, 8);
            clear_stim();
            for (int i = 0; i < cnt; i++) push_word($urandom, 1'b1);
            close_load();
            pulse_start(cnt);
            feed(2);
            wait_done(50);
            n_tests++;
            if (wd_q.size() != cnt || csum_err !== 1'b0) begin
                n_fail++;
                $display("FAIL rand%0d_count: %0d writes err=%b, want %0d/0", it, wd_q.size(), csum_err, cnt);
            end
            foreach (exp_q[i]) if (i < wd_q.size()) begin
                n_tests++;
                if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand%0d_w%0d: %0d/%h want %0d/%h", it, i, wa_q[i], wd_q[i], i, exp_q[i]);
                end
            end
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [31:0] sums[2] = '{32'h00008003, 32'h00008004};
        foreach (sums[s]) begin
            clear_stim();
            push_word(32'hf8000001, 1'b1);
            push_word(32'hf8008002, 1'b1);
            push_word(sums[s], 1'b0);
            pulse_start(2);
            feed(0);
            wait_done(20);
            n_tests++;
            if (csum_err !== 1'(s) || wd_q.size() != 2 || cpu_hold !== 1'b0) begin
                n_fail++;
                $display("FAIL csum%0d: err=%b writes=%0d hold=%b, want %0d/2/0",
                         s, csum_err, wd_q.size(), cpu_hold, s);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_full();
        test_reset_mid();
        test_corner();
        test_random();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
